// File: rtl/hazard_unit.sv
`default_nettype none
// =============================================================================
// Module   : hazard_unit
// Purpose  : Pipeline interlock beside the decode stage. Generates the PC,
//            IF/ID, control-unit and EX/MEM enables, the decode bubble and the
//            IF/ID flush. Also selects operand forwarding sources, waits on the
//            D-cache with a timeout, and counts stall cycles.
//
// Build option:
//   HAZARD_FORWARDING_EN  defined   -> EX/MEM forwarding; only load-use stalls
//                         undefined -> no forwarding; any RAW match stalls
//
// Parameters:
//   MEM_TIMEOUT  consecutive D-cache wait cycles before o_mem_err is raised
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   i_id_opcode/rs/rt    instruction currently in decode
//   i_ex_*               EX-stage regwrite / load / destination
//   i_mem_*              MEM-stage regwrite / load / store / destination
//   i_branch_taken       MEM-stage branch resolved taken
//   i_dcache_ready       D-cache completes the MEM access this cycle
//   o_pc_we, o_ifid_we, o_ctrl_we, o_exmem_we   pipeline enables
//   o_bubble             decode substitutes OP_STALL for the opcode
//   o_flush_ifid         clear IF/ID to OP_STALL
//   o_fwd_a, o_fwd_b     0 reg file, 1 from MEM, 2 from WB
//   o_mem_err            sticky D-cache timeout flag
//   o_stall_cnt          saturating count of cycles with PC held
//
// Revision : 1.0 - initial release
// =============================================================================
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       i_id_opcode,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_memread,
  input  logic             i_mem_memwrite,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_branch_taken,
  input  logic             i_dcache_ready,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_ctrl_we,
  output logic             o_exmem_we,
  output logic             o_bubble,
  output logic             o_flush_ifid,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Opcode map shared with the decode stage
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h01;
  localparam logic [5:0] c_OP_ANDI  = 6'h02;
  localparam logic [5:0] c_OP_ORI   = 6'h03;
  localparam logic [5:0] c_OP_LDB   = 6'h04;
  localparam logic [5:0] c_OP_LDW   = 6'h05;
  localparam logic [5:0] c_OP_STB   = 6'h06;
  localparam logic [5:0] c_OP_STW   = 6'h07;
  localparam logic [5:0] c_OP_BEQ   = 6'h08;
  localparam logic [5:0] c_OP_BNE   = 6'h09;
  localparam logic [5:0] c_OP_JUMP  = 6'h0A;
  localparam logic [5:0] c_OP_LI    = 6'h0B;
  localparam logic [5:0] c_OP_LUI   = 6'h0C;
  localparam logic [5:0] c_OP_STALL = 6'h3F;

  localparam int                    c_WCNT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0]   c_TIMEOUT = c_WCNT_W'(MEM_TIMEOUT);
  localparam logic [c_WCNT_W-1:0]   c_WONE    = c_WCNT_W'(1);
  localparam logic [CNT_W-1:0]      c_CONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_ERROR   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_WCNT_W-1:0] r_wait_cnt;
  logic [c_WCNT_W-1:0] w_wait_next;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_uses_rs, w_uses_rt;
  logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic w_hazard, w_miss, w_flow, w_err_set;
  logic w_pc_we, w_ifid_we, w_ctrl_we, w_exmem_we, w_bubble, w_flush;
  logic [1:0] w_fwd_a, w_fwd_b;

  // ---------------------------------------------------------------------------
  // Operand usage; jumps, immediates loads, OP_STALL and unknown opcodes read
  // no source register.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_uses_rs = 1'b0;
    w_uses_rt = 1'b0;
    case (i_id_opcode)
      c_OP_RTYPE, c_OP_STB, c_OP_STW, c_OP_BEQ, c_OP_BNE: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
      end
      c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LDB, c_OP_LDW: w_uses_rs = 1'b1;
      c_OP_JUMP, c_OP_LI, c_OP_LUI, c_OP_STALL:             w_uses_rs = 1'b0;
      default:                                             w_uses_rs = 1'b0;
    endcase
  end

  // Register 0 is hard-wired, so it never matches
  assign w_rs_ex  = (i_id_rs != 5'd0) && (i_id_rs == i_ex_rd);
  assign w_rt_ex  = (i_id_rt != 5'd0) && (i_id_rt == i_ex_rd);
  assign w_rs_mem = (i_id_rs != 5'd0) && (i_id_rs == i_mem_rd);
  assign w_rt_mem = (i_id_rt != 5'd0) && (i_id_rt == i_mem_rd);

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: one bubble
  assign w_hazard = i_ex_memread && ((w_uses_rs && w_rs_ex) || (w_uses_rt && w_rt_ex));

  // The younger (EX) producer holds the newest value, so it wins over MEM
  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (i_ex_regwrite && w_rs_ex)        w_fwd_a = 2'd1;
    else if (i_mem_regwrite && w_rs_mem) w_fwd_a = 2'd2;
    if (i_ex_regwrite && w_rt_ex)        w_fwd_b = 2'd1;
    else if (i_mem_regwrite && w_rt_mem) w_fwd_b = 2'd2;
  end
`else
  // Without forwarding every in-flight producer of a used source stalls
  assign w_hazard = (w_uses_rs && ((i_ex_regwrite && w_rs_ex) || (i_mem_regwrite && w_rs_mem)))
                 || (w_uses_rt && ((i_ex_regwrite && w_rt_ex) || (i_mem_regwrite && w_rt_mem)));
  assign w_fwd_a  = 2'd0;
  assign w_fwd_b  = 2'd0;

  // Load flag only matters when forwarding resolves the other RAW cases
  logic w_unused_ex_memread;
  assign w_unused_ex_memread = i_ex_memread;
`endif

  assign w_miss = (i_mem_memread || i_mem_memwrite) && !i_dcache_ready;

  // ---------------------------------------------------------------------------
  // Next state and enables. w_flow selects the normal branch/hazard/run rules,
  // used in RUN and on the cycle a pending D-cache access completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_err_set    = 1'b0;
    w_flow       = 1'b0;
    w_pc_we      = 1'b0;
    w_ifid_we    = 1'b0;
    w_ctrl_we    = 1'b0;
    w_exmem_we   = 1'b0;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_miss) begin
          // The miss cycle itself is the first wait cycle
          w_wait_next = c_WONE;
          if (c_WONE >= c_TIMEOUT) begin
            w_err_set    = 1'b1;
            w_state_next = S_ERROR;
          end else begin
            w_state_next = S_MEMWAIT;
          end
        end else begin
          w_flow = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (!i_dcache_ready) begin
          w_wait_next = r_wait_cnt + c_WONE;
          if (w_wait_next >= c_TIMEOUT) begin
            w_err_set    = 1'b1;
            w_state_next = S_ERROR;
          end
        end else begin
          w_flow       = 1'b1;
          w_wait_next  = '0;
          w_state_next = S_RUN;
        end
      end
      S_ERROR: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_bubble     = 1'b1;
        w_wait_next  = '0;
        w_state_next = S_RUN;
      end
    endcase

    if (w_flow) begin
      w_pc_we    = 1'b1;
      w_ifid_we  = 1'b1;
      w_ctrl_we  = 1'b1;
      w_exmem_we = 1'b1;
      if (i_branch_taken) begin
        // Wrong-path instruction in decode is squashed; fetch redirects
        w_bubble = 1'b1;
        w_flush  = 1'b1;
      end else if (w_hazard) begin
        w_pc_we   = 1'b0;
        w_ifid_we = 1'b0;
        w_bubble  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
      if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + c_CONE;
      end
    end
  end

  // Reset freezes the pipeline and bubbles decode regardless of state
  assign o_pc_we      = w_pc_we    && !reset;
  assign o_ifid_we    = w_ifid_we  && !reset;
  assign o_ctrl_we    = w_ctrl_we  && !reset;
  assign o_exmem_we   = w_exmem_we && !reset;
  assign o_bubble     = w_bubble   || reset;
  assign o_flush_ifid = w_flush    && !reset;
  assign o_fwd_a      = reset ? 2'd0 : w_fwd_a;
  assign o_fwd_b      = reset ? 2'd0 : w_fwd_b;
  assign o_mem_err    = r_mem_err;
  assign o_stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock block that consumes the decode-stage control signals (regwrite, memread, memwrite, branch) carried down the pipeline.
- Produces the stall, bubble and flush controls that gate the PC, the IF/ID register, the control unit's `we` input and the EX/MEM register.
- Sits beside the decode stage. On `bubble`, the decode stage substitutes `OP_STALL` for the opcode fed to the control unit.
- Contains a data-cache wait state machine with timeout, plus a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 64, maximum consecutive D-cache wait cycles before `mem_err` is raised.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- id_opcode  in  6  opcode of the instruction in decode
- id_rs  in  5  source register 1 in decode
- id_rt  in  5  source register 2 in decode
- ex_regwrite  in  1  EX-stage instruction writes a register
- ex_memread  in  1  EX-stage instruction is a load
- ex_rd  in  5  EX-stage destination register
- mem_regwrite  in  1  MEM-stage instruction writes a register
- mem_memread  in  1  MEM-stage load
- mem_memwrite  in  1  MEM-stage store
- mem_rd  in  5  MEM-stage destination register
- branch_taken  in  1  MEM-stage branch resolved taken
- dcache_ready  in  1  D-cache completes the MEM access this cycle
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ctrl_we  out  1  drives control unit `we`
- exmem_we  out  1  EX/MEM and MEM/WB register enable
- bubble  out  1  force `OP_STALL` into decode
- flush_ifid  out  1  clear IF/ID to `OP_STALL`
- fwd_a  out  2  src1 forward select: 0 reg file, 1 from MEM, 2 from WB
- fwd_b  out  2  src2 forward select, same encoding
- mem_err  out  1  sticky D-cache timeout flag
- stall_cnt  out  CNT_W  count of cycles with pc_we=0

Behaviour:
- Reset (asynchronous, active-high): state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
- While reset is high, all outputs are forced: pc_we=0, ifid_we=0, ctrl_we=0, exmem_we=0, bubble=1, flush_ifid=0, fwd_a=fwd_b=0.
- Reset mid-wait: abandons the wait with no error.
- Operand usage:
  - uses_rs is 1 for all opcodes except `OP_JUMP`, `OP_LI`, `OP_LUI`, `OP_STALL` and unknown opcodes.
  - uses_rt is 1 for `OP_RTYPE`, `OP_STB`, `OP_STW`, `OP_BEQ`, `OP_BNE`.
- Register 0 never causes a hazard or a forward.
- Outputs are combinational from the state and inputs; the state and counters are registered.
- States:
  - RUN: normal flow.
  - MEMWAIT: D-cache access pending.
  - ERROR: timeout reached; the pipeline stays frozen until reset.
- RUN, priority order within a cycle:
  1. Memory miss: (mem_memread|mem_memwrite) & ~dcache_ready → all enables=0, bubble=0. Next state MEMWAIT, counter=1.
  2. branch_taken → flush_ifid=1, bubble=1, pc_we=1, ifid_we=1, ctrl_we=1, exmem_we=1. Takes priority over a data hazard in the same cycle. Single cycle only.
  3. Data hazard → pc_we=0, ifid_we=0, bubble=1, ctrl_we=1, exmem_we=1. Re-evaluated every cycle.
  4. Otherwise all enables=1, bubble=0, flush_ifid=0.
- MEMWAIT:
  - All enables=0 while ~dcache_ready; counter increments.
  - When dcache_ready=1: enables follow the RUN rules 2–4 in that same cycle, next state RUN.
  - If counter reaches MEM_TIMEOUT while still not ready: mem_err←1, next state ERROR.
- ERROR: all enables=0, bubble=1, mem_err=1.
- stall_cnt: +1 on every non-reset cycle with pc_we=0. Saturates at all-ones; no wrap.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - Data hazard only when ex_memread & ex_rd≠0 & ((uses_rs & ex_rd==id_rs) | (uses_rt & ex_rd==id_rt)) (load-use, 1 bubble).
  - fwd_a: 1 if ex_regwrite & ex_rd==id_rs≠0; else 2 if mem_regwrite & mem_rd==id_rs≠0; else 0. EX match wins over MEM. fwd_b is analogous with id_rt.
- Undefined:
  - Data hazard on any match of id_rs/id_rt against ex_rd (when ex_regwrite) or mem_rd (when mem_regwrite), nonzero, with the uses_* gating as above.
  - fwd_a=fwd_b=0 constant.

Test Plan:
- Reset asserted mid-MEMWAIT with counter=5 → all enables=0 and bubble=1 immediately; after release state=RUN, stall_cnt=0, mem_err=0.
- Load-use: ex_memread=1, ex_rd=3, id_opcode=`OP_RTYPE`, id_rs=3 → pc_we=0, ifid_we=0, bubble=1 for exactly 1 cycle with forwarding; with forwarding off, also stalls while mem_rd=3 and mem_regwrite=1 (2 cycles total).
- Forward select: ex_regwrite=1, ex_rd=5, mem_regwrite=1, mem_rd=5, id_rt=5, opcode `OP_STW` → fwd_b=1; with ex_rd=0 → fwd_b=2 (forwarding on).
- mem_memread=1, dcache_ready low for 3 cycles then high → all enables=0 for 3 cycles, RUN on the 4th; stall_cnt=3.
- branch_taken=1 together with a load-use match → flush_ifid=1, bubble=1, pc_we=1 for 1 cycle.
- dcache_ready held 0 with MEM_TIMEOUT=4 → mem_err=1 after 4 wait cycles; state ERROR persists with dcache_ready=1 until reset.
